// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Holds the FSM state encoding, access size codes and parameter defaults.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  // Size code 11 is a word access on the memory side.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    logic [1:0] r;
    case (sz)
      SZ_B:    r = SZ_B;
      SZ_H:    r = SZ_H;
      default: r = SZ_W;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, with the starvation
// counter that forces a fetch grant after STARVE_MAX back-to-back data grants.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic pick_if_o,
  output logic pick_d_o
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  // Data wins a tie unless the fetch side has waited through STARVE_MAX grants.
  always_comb begin
    pick_if_o = 1'b0;
    pick_d_o  = 1'b0;
    if (d_req_i && if_req_i) begin
      if (starve_q == STARVE_LIM) begin
        pick_if_o = 1'b1;
      end else begin
        pick_d_o = 1'b1;
      end
    end else if (d_req_i) begin
      pick_d_o = 1'b1;
    end else if (if_req_i) begin
      pick_if_o = 1'b1;
    end else begin
      pick_if_o = 1'b0;
      pick_d_o  = 1'b0;
    end
  end

  // Next starvation count; only grants taken in IDLE move it.
  always_comb begin
    starve_d = starve_q;
    if (sample_i && pick_if_o) begin
      starve_d = '0;
    end else if (sample_i && pick_d_o && if_req_i && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch master and a
// data master; one transaction at a time with a per-transaction timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(TIMEOUT);

  arb_state_e    state_q;
  logic [WW-1:0] wait_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [1:0]    m_size_q;
  logic [31:0]   m_addr_q;
  logic [31:0]   m_wdata_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          if_ack_q;
  logic          d_ack_q;
  logic          err_q;

  logic          in_idle;
  logic          pick_if;
  logic          pick_d;

  assign in_idle = (state_q == IDLE);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .sample_i  (in_idle),
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .pick_if_o (pick_if),
    .pick_d_o  (pick_d)
  );

  // Transaction FSM with its wait counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_size_q   <= 2'b00;
      m_addr_q   <= 32'h0000_0000;
      m_wdata_q  <= 32'h0000_0000;
      if_rdata_q <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          err_q    <= 1'b0;
          wait_q   <= '0;
          if (pick_d) begin
            state_q   <= GNT_D;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_size_q  <= norm_size(d_size);
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
          end else if (pick_if) begin
            state_q   <= GNT_IF;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_size_q  <= SZ_W;
            m_addr_q  <= if_addr;
            m_wdata_q <= 32'h0000_0000;
          end else begin
            state_q <= IDLE;
            m_req_q <= 1'b0;
          end
        end
        GNT_IF, GNT_D: begin
          // Completion beats timeout when both land on the same cycle.
          if (m_ready || (wait_q == WAIT_LIM)) begin
            state_q <= RESP;
            m_req_q <= 1'b0;
            err_q   <= ~m_ready;
            if (state_q == GNT_IF) begin
              if_rdata_q <= m_ready ? m_rdata : 32'h0000_0000;
              if_ack_q   <= 1'b1;
            end else begin
              d_rdata_q <= m_ready ? m_rdata : 32'h0000_0000;
              d_ack_q   <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        RESP: begin
          state_q  <= IDLE;
          m_req_q  <= 1'b0;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          err_q    <= 1'b0;
          wait_q   <= '0;
        end
        default: begin
          state_q  <= IDLE;
          m_req_q  <= 1'b0;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          err_q    <= 1'b0;
          wait_q   <= '0;
        end
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_size   = m_size_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-schedule reference
// model: each grant books its m_req window and the cycle and content of its ack.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, m_ready;
  logic [1:0]  d_size;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, d_ack, err, m_req, m_we;
  logic [1:0]  m_size;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle: got %h expected %h", tag, got, exp);
    end
  endtask

  // Requester-side bookkeeping
  bit          if_pend, d_pend, drop_req;
  // Booked transaction
  bit          txn_live, who_if, exp_err, exp_store;
  int          g_cyc, rdy_cyc, ack_cyc, free_cyc, streak;
  logic [31:0] exp_data, exp_addr, exp_wdata;
  logic        exp_we;
  logic [1:0]  exp_size;

  task automatic clear_model(input int cyc);
    txn_live = 1'b0; if_pend = 1'b0; d_pend = 1'b0; drop_req = 1'b0;
    streak = 0; free_cyc = cyc + 1;
    if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
  endtask

  task automatic run_phase(input int ncyc, input int p_if, input int p_d,
                           input int max_lat, input int reset_at, inout int cyc);
    bit in_win, ack_now, did_reset, both, win_if;
    int lat;
    did_reset = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst = 1'b0;
      // Compare this cycle's outputs with the booked schedule.
      in_win  = txn_live && (cyc > g_cyc) && (cyc < ack_cyc);
      ack_now = txn_live && (cyc == ack_cyc);
      check_eq("m_req", {31'd0, m_req}, {31'd0, in_win});
      if (in_win) begin
        check_eq("m_addr",  m_addr,  exp_addr);
        check_eq("m_we",    {31'd0, m_we}, {31'd0, exp_we});
        check_eq("m_size",  {30'd0, m_size}, {30'd0, exp_size});
        check_eq("m_wdata", m_wdata, exp_wdata);
      end
      check_eq("if_ack", {31'd0, if_ack}, {31'd0, ack_now && who_if});
      check_eq("d_ack",  {31'd0, d_ack},  {31'd0, ack_now && !who_if});
      check_eq("err",    {31'd0, err},    {31'd0, ack_now && exp_err});
      if (ack_now) begin
        if (who_if) check_eq("if_rdata", if_rdata, exp_data);
        else if (!exp_store) check_eq("d_rdata", d_rdata, exp_data);
        if (who_if) if_pend = 1'b0; else d_pend = 1'b0;
        txn_live = 1'b0; drop_req = 1'b0; free_cyc = cyc + 1;
      end
      // Mid-transaction reset: outputs must clear without waiting for a clock.
      if (!did_reset && reset_at >= 0 && i >= reset_at && in_win) begin
        did_reset = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rst_m_req", {31'd0, m_req}, 32'd0);
        check_eq("rst_acks",  {30'd0, if_ack, d_ack}, 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        clear_model(cyc);
        cyc++;
        continue;
      end
      // New requests from idle requesters; hold fields while pending.
      if (!if_pend && ($urandom_range(0, 99) < p_if)) begin
        if_pend = 1'b1;
        if_addr = {1'b0, $urandom_range(0, 32'h0FFF_FFFF) * 4};
        if_addr[31] = 1'b0;
      end
      if (!d_pend && ($urandom_range(0, 99) < p_d)) begin
        d_pend  = 1'b1;
        d_we    = $urandom_range(0, 1);
        d_size  = $urandom_range(0, 3);
        d_addr  = $urandom; d_addr[31] = 1'b1;
        d_wdata = $urandom;
      end
      if (txn_live && in_win && ($urandom_range(0, 99) < 10)) drop_req = 1'b1;
      if_req = if_pend && !(txn_live && who_if && drop_req);
      d_req  = d_pend  && !(txn_live && !who_if && drop_req);
      // Grant decision for an idle arbiter.
      if (!txn_live && (cyc >= free_cyc) && (if_req || d_req)) begin
        both   = if_req && d_req;
        win_if = both ? (streak == SMAX) : if_req;
        if (win_if) streak = 0;
        else if (if_req) streak = (streak < SMAX) ? streak + 1 : SMAX;
        txn_live = 1'b1; who_if = win_if; g_cyc = cyc;
        exp_addr  = win_if ? if_addr : d_addr;
        exp_we    = win_if ? 1'b0 : d_we;
        exp_size  = win_if ? SZ_W : ((d_size == 2'b11) ? SZ_W : d_size);
        exp_wdata = win_if ? 32'd0 : d_wdata;
        exp_store = !win_if && d_we;
        lat = $urandom_range(0, max_lat);
        if (lat <= TMO) begin
          rdy_cyc = cyc + 1 + lat; ack_cyc = rdy_cyc + 1;
          exp_err = 1'b0; exp_data = $urandom;
        end else begin
          rdy_cyc = -1; ack_cyc = cyc + 1 + TMO + 1;
          exp_err = 1'b1; exp_data = 32'd0;
        end
      end
      // Memory side; stray strobes outside the grant window must be ignored.
      in_win = txn_live && (cyc > g_cyc) && (cyc < ack_cyc);
      if (txn_live && cyc == rdy_cyc) begin
        m_ready = 1'b1; m_rdata = exp_data;
      end else if (in_win) begin
        m_ready = 1'b0; m_rdata = $urandom;
      end else begin
        m_ready = ($urandom_range(0, 99) < 20); m_rdata = $urandom;
      end
      cyc++;
    end
  endtask

  int cyc;
  int lat_first;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; m_ready = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; m_rdata = 32'd0;
    #1;
    check_eq("reset_m_req", {31'd0, m_req}, 32'd0);
    check_eq("reset_ack",   {29'd0, if_ack, d_ack, err}, 32'd0);
    check_eq("reset_m_addr", m_addr, 32'd0);
    check_eq("reset_rdata", if_rdata | d_rdata, 32'd0);
    repeat (2) @(posedge clk);
    cyc = 0;
    clear_model(-1);

    // Directed fetch: 0x100, m_ready one cycle after m_req, ack at N+3.
    @(negedge clk);
    rst = 1'b0; if_addr = 32'h0000_0100; if_req = 1'b1;
    @(negedge clk);
    check_eq("dir_m_req", {31'd0, m_req}, 32'd1);
    check_eq("dir_m_addr", m_addr, 32'h0000_0100);
    @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    m_ready = 1'b0; if_req = 1'b0;
    check_eq("dir_if_ack", {31'd0, if_ack}, 32'd1);
    check_eq("dir_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check_eq("dir_err", {31'd0, err}, 32'd0);
    lat_first = 0;

    // Random phases: mixed traffic, saturated traffic (starvation), resets.
    clear_model(cyc);
    run_phase(1500, 40, 40, TMO + 3, -1, cyc);
    run_phase(800, 100, 100, 3, -1, cyc);
    run_phase(600, 50, 60, TMO + 3, 200, cyc);
    run_phase(400, 30, 70, TMO + 3, 100, cyc);
    // Drain: let any booked transaction complete and be checked.
    run_phase(2 * TMO + 4, 0, 0, TMO + 3, -1, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
